dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_ram_array.sv | 23 ++
 rtl/dmem_responder.sv | 145 ++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: MMIO register offsets and the
// region-select encoding that picks the read-data source.
package dmem_pkg;

    localparam logic [1:0] MMIO_LED    = 2'd0;
    localparam logic [1:0] MMIO_SWITCH = 2'd1;
    localparam logic [1:0] MMIO_CYCLES = 2'd2;
    localparam logic [1:0] MMIO_STATUS = 2'd3;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_OOR
    } region_t;

endpackage

// File: rtl/dmem_ram_array.sv
// Single-port synchronous RAM, read-first, with registered read data.
// Contents are intentionally not reset.
module dmem_ram_array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_BITS   = 12
) (
    input  logic                 clock,
    input  logic                 wrEn,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wrData,
    output logic [31:0]          rdData
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        rdData <= mem[addr];
        if (wrEn) begin
            mem[addr] <= wrData;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Processor dmem responder: word RAM plus LED/switch/cycle/status MMIO window.
// Define DMEM_BOUNDS_TRAP_EN to trap out-of-range accesses; otherwise they alias into RAM.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned ADDR_BITS   = 12,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
    parameter int unsigned SW_WIDTH    = 8,
    parameter int unsigned LED_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          address_dmem,
    input  logic [31:0]          data,
    input  logic                 wren,
    output logic [31:0]          q_dmem,
    input  logic [SW_WIDTH-1:0]  switches,
    output logic [LED_WIDTH-1:0] leds,
    output logic                 fault
);

    region_t             region;
    region_t             regionQ;
    logic [31:0]         mmioOffsetFull;
    logic [1:0]          mmioOffset;
    logic                inMmio;
    logic                mmioWrite;
    logic                ramWrEn;
    logic [31:0]         ramQ;
    logic [31:0]         mmioRd;
    logic [31:0]         mmioQ;
    logic [SW_WIDTH-1:0] swMeta;
    logic [SW_WIDTH-1:0] swSync;
    logic [31:0]         cycles;
`ifdef DMEM_BOUNDS_TRAP_EN
    logic [30:0]         faultAddr;
    logic                statusClear;
`endif

    // Subtract-then-check-high-bits avoids overflow of MMIO_BASE+3.
    assign mmioOffsetFull = address_dmem - MMIO_BASE;
    assign inMmio         = (address_dmem >= MMIO_BASE) && (mmioOffsetFull[31:2] == '0);
    assign mmioOffset     = mmioOffsetFull[1:0];

    always_comb begin
        region = REGION_OOR;
        if (inMmio) begin
            region = REGION_MMIO;
        end
`ifdef DMEM_BOUNDS_TRAP_EN
        else if (address_dmem < 32'(DEPTH_WORDS)) begin
            region = REGION_RAM;
        end
`else
        else begin
            region = REGION_RAM;
        end
`endif
    end

    assign mmioWrite = wren && (region == REGION_MMIO);
    assign ramWrEn   = wren && (region == REGION_RAM) && !reset;

    dmem_ram_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_BITS  (ADDR_BITS)
    ) ramArray (
        .clock (clock),
        .wrEn  (ramWrEn),
        .addr  (address_dmem[ADDR_BITS-1:0]),
        .wrData(data),
        .rdData(ramQ)
    );

    always_comb begin
        mmioRd = '0;
        case (mmioOffset)
            MMIO_LED:    mmioRd = 32'(leds);
            MMIO_SWITCH: mmioRd = 32'(swSync);
            MMIO_CYCLES: mmioRd = cycles;
`ifdef DMEM_BOUNDS_TRAP_EN
            MMIO_STATUS: mmioRd = {faultAddr, fault};
`else
            MMIO_STATUS: mmioRd = '0;
`endif
            default:     mmioRd = '0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            regionQ <= REGION_OOR;
            mmioQ   <= '0;
            leds    <= '0;
            swMeta  <= '0;
            swSync  <= '0;
            cycles  <= '0;
        end else begin
            regionQ <= region;
            mmioQ   <= mmioRd;
            swMeta  <= switches;
            swSync  <= swMeta;
            if (mmioWrite && (mmioOffset == MMIO_LED)) begin
                leds <= data[LED_WIDTH-1:0];
            end
            if (mmioWrite && (mmioOffset == MMIO_CYCLES)) begin
                cycles <= '0;
            end else begin
                cycles <= cycles + 32'd1;
            end
        end
    end

`ifdef DMEM_BOUNDS_TRAP_EN
    assign statusClear = mmioWrite && (mmioOffset == MMIO_STATUS) && data[0];

    // Clear beats a coincident fault; otherwise the first fault address sticks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fault     <= 1'b0;
            faultAddr <= '0;
        end else if (statusClear) begin
            fault     <= 1'b0;
            faultAddr <= '0;
        end else if ((region == REGION_OOR) && !fault) begin
            fault     <= 1'b1;
            faultAddr <= address_dmem[30:0];
        end
    end
`else
    assign fault = 1'b0;
`endif

    // Reset parks regionQ on OOR so q_dmem reads zero without resetting the RAM.
    always_comb begin
        q_dmem = '0;
        case (regionQ)
            REGION_RAM:  q_dmem = ramQ;
            REGION_MMIO: q_dmem = mmioQ;
            default:     q_dmem = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: behavioural model plus directed vectors.
// Follows DMEM_BOUNDS_TRAP_EN the same way the design does.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 4096;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic        fault;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    dmem_responder #(
        .DEPTH_WORDS(4096),
        .ADDR_BITS  (12),
        .MMIO_BASE  (BASE),
        .SW_WIDTH   (8),
        .LED_WIDTH  (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .q_dmem      (q_dmem),
        .switches    (switches),
        .leds        (leds),
        .fault       (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: memory as a plain array, registers as plain variables.
    logic [31:0] mMem [DEPTH];
    bit          mKnown [DEPTH];
    logic [31:0] mQ         = '0;
    bit          mQKnown    = 1'b1;
    logic [7:0]  mLeds      = '0;
    logic [7:0]  mSw1       = '0;
    logic [7:0]  mSw2       = '0;
    logic [31:0] mCycles    = '0;
    logic        mFault     = 1'b0;
    logic [30:0] mFaultAddr = '0;

    always @(posedge clock or posedge reset) begin : model
        logic [31:0] a;
        bit          isMmio;
        bit          isRam;
        int unsigned idx;
        logic [1:0]  off;
        if (reset) begin
            mQ = '0; mQKnown = 1'b1; mLeds = '0; mSw1 = '0; mSw2 = '0;
            mCycles = '0; mFault = 1'b0; mFaultAddr = '0;
        end else begin
            a      = address_dmem;
            isMmio = (a >= BASE) && ((a - BASE) < 32'd4);
`ifdef DMEM_BOUNDS_TRAP_EN
            isRam  = a < DEPTH;
`else
            isRam  = !isMmio;
`endif
            idx = a % DEPTH;
            off = 2'(a - BASE);
            mQKnown = 1'b1;
            if (isRam) begin
                mQ = mMem[idx];
                mQKnown = mKnown[idx];
            end else if (isMmio) begin
                case (off)
                    2'd0: mQ = {24'h0, mLeds};
                    2'd1: mQ = {24'h0, mSw2};
                    2'd2: mQ = mCycles;
`ifdef DMEM_BOUNDS_TRAP_EN
                    default: mQ = {mFaultAddr, mFault};
`else
                    default: mQ = '0;
`endif
                endcase
            end else begin
                mQ = '0;
            end
            mCycles = mCycles + 1;
            if (wren && isRam) begin
                mMem[idx] = data;
                mKnown[idx] = 1'b1;
            end
            if (wren && isMmio && off == 2'd0) mLeds = data[7:0];
            if (wren && isMmio && off == 2'd2) mCycles = '0;
`ifdef DMEM_BOUNDS_TRAP_EN
            if (wren && isMmio && off == 2'd3 && data[0]) begin
                mFault = 1'b0;
                mFaultAddr = '0;
            end else if (!isRam && !isMmio && !mFault) begin
                mFault = 1'b1;
                mFaultAddr = a[30:0];
            end
`endif
            mSw2 = mSw1;
            mSw1 = switches;
        end
    end

    always @(negedge clock) begin
        if (mQKnown) check("model_q_dmem", q_dmem, mQ);
        check("model_leds", 32'(leds), 32'(mLeds));
        check("model_fault", 32'(fault), 32'(mFault));
    end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        address_dmem = a;
        data = d;
        wren = w;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        address_dmem = '0;
        data = '0;
        wren = 1'b0;
        switches = '0;
        repeat (2) @(negedge clock);
        check("reset_q", q_dmem, 32'h0);
        check("reset_leds", 32'(leds), 32'h0);
        check("reset_fault", 32'(fault), 32'h0);
        reset = 1'b0;

        repeat (9) step(32'h0, 32'h0, 1'b0);
        step(BASE + 2, 32'h0, 1'b0);
        check("cycles_tenth_edge", q_dmem, 32'd9);
        step(BASE + 2, 32'h1234, 1'b1);
        check("cycles_read_on_clear", q_dmem, 32'd10);
        step(32'h0, 32'h0, 1'b0);
        step(BASE + 2, 32'h0, 1'b0);
        check("cycles_after_clear", q_dmem, 32'd1);

        step(32'd5, 32'hDEAD_BEEF, 1'b1);
        step(32'd5, 32'h0, 1'b0);
        check("ram_read", q_dmem, 32'hDEAD_BEEF);
        step(32'd5, 32'h1, 1'b1);
        check("ram_read_first", q_dmem, 32'hDEAD_BEEF);
        step(32'd5, 32'h0, 1'b0);
        check("ram_new_value", q_dmem, 32'h1);

        step(BASE, 32'hFFFF_FFA5, 1'b1);
        check("led_output", 32'(leds), 32'hA5);
        step(BASE, 32'h0, 1'b0);
        check("led_readback", q_dmem, 32'h0000_00A5);

        switches = 8'h3C;
        step(32'h0, 32'h0, 1'b0);
        step(BASE + 1, 32'h0, 1'b0);
        check("switch_still_old", q_dmem, 32'h0);
        step(BASE + 1, 32'hFF, 1'b1);
        check("switch_synced", q_dmem, 32'h3C);

`ifdef DMEM_BOUNDS_TRAP_EN
        step(32'h0, 32'h0BAD_F00D, 1'b1);
        step(32'h2000, 32'h1234_5678, 1'b1);
        check("oor_fault_set", 32'(fault), 32'h1);
        check("oor_read_zero", q_dmem, 32'h0);
        step(32'h0, 32'h0, 1'b0);
        check("oor_write_dropped", q_dmem, 32'h0BAD_F00D);
        step(BASE + 3, 32'h0, 1'b0);
        check("status_first", q_dmem, 32'h0000_4001);
        step(32'h3000, 32'h0, 1'b0);
        step(BASE + 3, 32'h0, 1'b0);
        check("status_first_wins", q_dmem, 32'h0000_4001);
        step(BASE + 3, 32'h0, 1'b1);
        check("status_write0_noop", 32'(fault), 32'h1);
        step(BASE + 3, 32'h1, 1'b1);
        check("status_clear", 32'(fault), 32'h0);
        check("status_read_preclear", q_dmem, 32'h0000_4001);
        step(BASE + 3, 32'h0, 1'b0);
        check("status_cleared", q_dmem, 32'h0);
`else
        step(32'h1005, 32'h77, 1'b1);
        step(32'd5, 32'h0, 1'b0);
        check("alias_read", q_dmem, 32'h77);
        check("alias_no_fault", 32'(fault), 32'h0);
        step(BASE + 3, 32'h1, 1'b1);
        step(BASE + 3, 32'h0, 1'b0);
        check("status_reads_zero", q_dmem, 32'h0);
`endif

        step(32'd7, 32'h0000_CAFE, 1'b1);
        step(32'd7, 32'h0, 1'b0);
        check("pre_reset_value", q_dmem, 32'h0000_CAFE);
`ifdef DMEM_BOUNDS_TRAP_EN
        step(32'h2000, 32'h0, 1'b0);
`endif
        address_dmem = 32'd7;
        data = 32'h0000_0BAD;
        wren = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_reset_q", q_dmem, 32'h0);
        check("async_reset_leds", 32'(leds), 32'h0);
        check("async_reset_fault", 32'(fault), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        step(32'd7, 32'h0, 1'b0);
        check("write_in_reset_dropped", q_dmem, 32'h0000_CAFE);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
